math_arith_unit: RTL



---
 rtl/math_arith_pkg.sv | 20 ++
 rtl/math_arith_mul_seq.sv | 39 +++
 rtl/math_arith_unit.sv | 99 +++++++++
 3 files changed

// File: rtl/math_arith_pkg.sv
// math_arith_pkg: opcodes, FSM states and reduction-flag bit positions shared by the arithmetic unit
package math_arith_pkg;
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_SHL  = 3'd3,
    OP_SHR  = 3'd4,
    OP_ASR  = 3'd5,
    OP_IMPL = 3'd6,
    OP_EQV  = 3'd7
  } op_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  localparam int RED_OR   = 0;
  localparam int RED_NOR  = 1;
  localparam int RED_AND  = 2;
  localparam int RED_NAND = 3;
  localparam int RED_XOR  = 4;
  localparam int RED_XNOR = 5;
endpackage

// File: rtl/math_arith_mul_seq.sv
// math_arith_mul_seq: shift-add multiplier, one multiplier bit per step, LSB first
module math_arith_mul_seq #(
  parameter int WIDTH = 68
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  // product is the accumulator after the current step, so the last step's value can be captured on the same edge
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = step & (cnt == CW'(1));
  // load operands on start, then accumulate one partial product per step until cnt runs out
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= CW'(WIDTH);
    end else if (step && cnt != '0) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
endmodule

// File: rtl/math_arith_unit.sv
// math_arith_unit: handshaked multi-cycle ALU with iterative multiply and reduction flags of a
module math_arith_unit
  import math_arith_pkg::*;
#(
  parameter int WIDTH = 68,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic [5:0]       red
);
  state_e                   state_q, state_d;
  op_e                      opc;
  logic                     accept, mul_done, big;
  logic [2*WIDTH-1:0]       mul_prod, shl_w;
  logic [WIDTH:0]           sum, diff;
  logic signed [WIDTH-1:0]  asr;
  logic [SHW-1:0]           amt;
  logic [WIDTH-1:0]         alu_res;
  logic                     alu_ovf;
  logic [5:0]               red_in;
  assign opc      = op_e'(op);
  assign in_ready = state_q == IDLE;
  assign accept   = in_valid & in_ready;
  // amounts at or beyond WIDTH saturate; below that only the low SHW bits matter
  assign big      = b >= WIDTH'(WIDTH);
  assign amt      = b[SHW-1:0];
  assign sum      = {1'b0, a} + {1'b0, b};
  assign diff     = {1'b0, a} - {1'b0, b};
  assign shl_w    = {{WIDTH{1'b0}}, a} << amt;
  assign asr      = $signed(a) >>> amt;
  assign red_in[RED_OR]   = |a;
  assign red_in[RED_NOR]  = ~|a;
  assign red_in[RED_AND]  = &a;
  assign red_in[RED_NAND] = ~&a;
  assign red_in[RED_XOR]  = ^a;
  assign red_in[RED_XNOR] = ~^a;
  assign alu_res = opc == OP_ADD  ? sum[WIDTH-1:0] :
                   opc == OP_SUB  ? diff[WIDTH-1:0] :
                   opc == OP_SHL  ? (big ? '0 : shl_w[WIDTH-1:0]) :
                   opc == OP_SHR  ? (big ? '0 : a >> amt) :
                   opc == OP_ASR  ? (big ? {WIDTH{a[WIDTH-1]}} : asr) :
                   opc == OP_IMPL ? WIDTH'((~|a) | (|b)) :
                   opc == OP_EQV  ? WIDTH'((|a) == (|b)) : '0;
  assign alu_ovf = opc == OP_ADD ? sum[WIDTH] :
                   opc == OP_SUB ? diff[WIDTH] :
                   opc == OP_SHL ? (big ? |a : |shl_w[2*WIDTH-1:WIDTH]) : 1'b0;
  math_arith_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && opc == OP_MUL),
    .step   (state_q == BUSY),
    .a      (a),
    .b      (b),
    .done   (mul_done),
    .product(mul_prod)
  );
  // next-state: multiply detours through BUSY, everything else goes straight to DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = opc == OP_MUL ? BUSY : DONE;
      BUSY:    if (mul_done) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; result/ovf/red only change on accept or multiply completion
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      red       <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= state_d == DONE;
      if (accept) begin
        red <= red_in;
        if (opc != OP_MUL) begin
          result <= alu_res;
          ovf    <= alu_ovf;
        end
      end else if (mul_done) begin
        result <= mul_prod[WIDTH-1:0];
        ovf    <= |mul_prod[2*WIDTH-1:WIDTH];
      end
    end
endmodule
